fetch_sequencer: RTL



---
 rtl/fetch_sequencer.sv | 88 ++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for the instruction ROM.
// Ports: CLK/Reset, Start/Stall/Halt/BranchRel/Offset/JumpAbs/Target in;
//        InstAddress (PC), InstValid, Done, CycleCt out.
module fetch_sequencer #(
  parameter int IW       = 8,
  parameter int START_PC = 0,
  parameter int OW       = 8,
  parameter int CW       = 16
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stall,
  input  logic          Halt,
  input  logic          BranchRel,
  input  logic [OW-1:0] Offset,
  input  logic          JumpAbs,
  input  logic [IW-1:0] Target,
  output logic [IW-1:0] InstAddress,
  output logic          InstValid,
  output logic          Done,
  output logic [CW-1:0] CycleCt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] PC0 = IW'(START_PC);

  logic [1:0]    state;
  logic [IW-1:0] pc;
  logic [IW-1:0] pc_next;
  logic [IW-1:0] off_ext;
  logic [CW-1:0] ct;
  logic          run;

  assign run     = (state == S_RUN);
  assign off_ext = IW'(signed'(Offset));

  // Halt and Stall both freeze the PC; the wrap is
  // the natural IW-bit overflow of the adders.
  always_comb begin
    pc_next = pc;
    if (Halt || Stall)
      pc_next = pc;
    else if (JumpAbs)
      pc_next = Target;
    else if (BranchRel)
      pc_next = pc + off_ext;
    else
      pc_next = pc + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IDLE;
      pc    <= PC0;
      ct    <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state <= S_RUN;
            pc    <= PC0;
            ct    <= '0;
          end
        end
        S_RUN: begin
          if (ct != '1)
            ct <= ct + 1'b1;
          pc <= pc_next;
          if (Halt)
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign InstAddress = pc;
  // Stall drops validity in the same cycle it is
  // raised, so decode never sees a held slot twice.
  assign InstValid   = run & ~Stall;
  assign Done        = (state == S_DONE);
  assign CycleCt     = ct;

endmodule
